// File: rtl/cmd_controller_pkg.sv
// ============================================================================
// cmd_controller_pkg : opcodes, reply bytes, FSM states and frame helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package cmd_controller_pkg;

  localparam logic [3:0] c_op_read  = 4'd1;
  localparam logic [3:0] c_op_write = 4'd2;
  localparam logic [3:0] c_op_draw  = 4'd3;
  localparam logic [3:0] c_op_fill  = 4'd4;

  localparam logic [7:0] c_ack_byte = 8'hA5;
  localparam logic [7:0] c_nak_byte = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_RX_FIELDS  = 4'd1,
    S_READ_REQ   = 4'd2,
    S_READ_WAIT  = 4'd3,
    S_READ_SEND  = 4'd4,
    S_READ_HOLD  = 4'd5,
    S_WRITE_DATA = 4'd6,
    S_FILL       = 4'd7,
    S_DRAW_WAIT  = 4'd8,
    S_ACK        = 4'd9
  } state_t;

  function automatic logic is_known_op(input logic [3:0] op);
    return (op == c_op_read) || (op == c_op_write) ||
           (op == c_op_draw) || (op == c_op_fill);
  endfunction

  // Number of bytes following the header (WRITE payload excluded).
  function automatic logic [7:0] field_total(input logic [3:0] op,
                                             input int unsigned addr_bytes,
                                             input int unsigned count_bytes);
    case (op)
      c_op_draw: return 8'(1 + addr_bytes);
      c_op_fill: return 8'(count_bytes + addr_bytes + 1);
      default:   return 8'(count_bytes + addr_bytes);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_timeout.sv
// ============================================================================
// cmd_timeout : inter-byte idle down-counter, expires after CYCLES idle cycles
// Revision 1.0
// ============================================================================
`default_nettype none

module cmd_timeout #(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (CYCLES == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
      localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);
      localparam logic [CW-1:0] ONE  = CW'(1);

      logic [CW-1:0] r_count;

      always_ff @(posedge clk) begin
        if (rst || clear) begin
          r_count <= LOAD;
        end else if (enable && (r_count != '0)) begin
          r_count <= r_count - ONE;
        end
      end

      assign expired = enable && !clear && (r_count == '0);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/cmd_controller.sv
// ============================================================================
// cmd_controller : UART frame parser driving memory READ/WRITE/FILL and GPU DRAW
// Revision 1.0
// ============================================================================
`default_nettype none

module cmd_controller
  import cmd_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned COUNT_WIDTH    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter bit          ACK_ENABLE     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  received,
  input  logic [7:0]            rx_byte,
  input  logic                  is_transmitting,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  gpu_draw,
  output logic [ADDR_WIDTH-1:0] gpu_addr,
  output logic [3:0]            gpu_lines,
  output logic [3:0]            gpu_x,
  output logic [3:0]            gpu_y,
  input  logic                  gpu_ready,
  output logic                  busy
);

  localparam int unsigned ADDR_BYTES  = (ADDR_WIDTH + 7) / 8;
  localparam int unsigned COUNT_BYTES = (COUNT_WIDTH + 7) / 8;
  localparam logic [7:0] CB8 = 8'(COUNT_BYTES);
  localparam logic [7:0] AB8 = 8'(ADDR_BYTES);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
  localparam state_t DONE_STATE = ACK_ENABLE ? S_ACK : S_IDLE;

  state_t                 r_state;
  logic [3:0]             r_op, r_arg;
  logic [7:0]             r_field_idx, r_value, r_xy, r_ack_byte, r_tx_byte;
  logic [ADDR_WIDTH-1:0]  r_addr, r_mem_addr, r_gpu_addr;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [7:0]             r_mem_wdata;
  logic                   r_transmit, r_mem_read, r_mem_write, r_gpu_draw;
  logic [3:0]             r_gpu_lines, r_gpu_x, r_gpu_y;

  logic                   w_armed, w_timeout, w_is_draw, w_last_field;
  logic                   w_in_count, w_in_addr, w_in_xy;
  logic [ADDR_WIDTH-1:0]  w_addr_next, w_addr_inc;
  logic [COUNT_WIDTH-1:0] w_count_next;

  // Multi-byte fields arrive big-endian, so each byte shifts in from the bottom.
  assign w_addr_next  = (r_addr << 8) | ADDR_WIDTH'(rx_byte);
  assign w_count_next = (r_count << 8) | COUNT_WIDTH'(rx_byte);
  assign w_addr_inc   = r_addr + ADDR_ONE;

  assign w_is_draw    = (r_op == c_op_draw);
  assign w_last_field = (r_field_idx == field_total(r_op, ADDR_BYTES, COUNT_BYTES) - 8'd1);
  assign w_in_xy      = w_is_draw && (r_field_idx == 8'd0);
  assign w_in_count   = !w_is_draw && (r_field_idx < CB8);
  assign w_in_addr    = w_is_draw ? (r_field_idx != 8'd0)
                                  : ((r_field_idx >= CB8) && (r_field_idx < CB8 + AB8));

  assign w_armed = (r_state == S_RX_FIELDS) || (r_state == S_WRITE_DATA);

  cmd_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (received || !w_armed),
    .enable  (w_armed),
    .expired (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;  r_arg       <= '0;
      r_field_idx <= '0;  r_value     <= '0;
      r_xy        <= '0;  r_ack_byte  <= '0;
      r_addr      <= '0;  r_count     <= '0;
      r_transmit  <= 1'b0; r_tx_byte  <= '0;
      r_mem_read  <= 1'b0; r_mem_write <= 1'b0;
      r_mem_addr  <= '0;  r_mem_wdata <= '0;
      r_gpu_draw  <= 1'b0; r_gpu_addr <= '0;
      r_gpu_lines <= '0;  r_gpu_x     <= '0;  r_gpu_y <= '0;
    end else begin
      r_transmit  <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_gpu_draw  <= 1'b0;
      case (r_state)
        S_IDLE: if (received) begin
          r_op        <= rx_byte[3:0];
          r_arg       <= rx_byte[7:4];
          r_field_idx <= '0;
          r_addr      <= '0;
          r_count     <= '0;
          r_ack_byte  <= c_nak_byte;
          r_state     <= is_known_op(rx_byte[3:0]) ? S_RX_FIELDS : DONE_STATE;
        end
        S_RX_FIELDS: if (w_timeout) begin
          r_ack_byte <= c_nak_byte;
          r_state    <= DONE_STATE;
        end else if (received) begin
          r_field_idx <= r_field_idx + 8'd1;
          if (w_in_count)     r_count <= w_count_next;
          else if (w_in_addr) r_addr  <= w_addr_next;
          else if (w_in_xy)   r_xy    <= rx_byte;
          else                r_value <= rx_byte;
          if (w_last_field) begin
            r_ack_byte <= c_ack_byte;
            case (r_op)
              c_op_read:  r_state <= S_READ_REQ;
              c_op_write: r_state <= S_WRITE_DATA;
              c_op_fill:  r_state <= S_FILL;
              default: begin
                // The final draw field is always an address byte.
                r_state     <= S_DRAW_WAIT;
                r_gpu_draw  <= 1'b1;
                r_gpu_addr  <= w_addr_next;
                r_gpu_lines <= r_arg;
                r_gpu_x     <= r_xy[7:4];
                r_gpu_y     <= r_xy[3:0];
              end
            endcase
          end
        end
        S_READ_REQ: if (!is_transmitting) begin
          r_mem_read <= 1'b1;
          r_mem_addr <= r_addr;
          r_state    <= S_READ_WAIT;
        end
        S_READ_WAIT: r_state <= S_READ_SEND;
        S_READ_SEND: begin
          r_transmit <= 1'b1;
          r_tx_byte  <= mem_rdata;
          r_state    <= S_READ_HOLD;
        end
        // Gives the transmitter a cycle to raise its busy flag.
        S_READ_HOLD: begin
          r_addr  <= w_addr_inc;
          r_count <= r_count - COUNT_ONE;
          r_state <= (r_count == '0) ? S_IDLE : S_READ_REQ;
        end
        S_WRITE_DATA: if (w_timeout) begin
          r_ack_byte <= c_nak_byte;
          r_state    <= DONE_STATE;
        end else if (received) begin
          r_mem_write <= 1'b1;
          r_mem_addr  <= r_addr;
          r_mem_wdata <= rx_byte;
          r_addr      <= w_addr_inc;
          r_count     <= r_count - COUNT_ONE;
          if (r_count == '0) r_state <= DONE_STATE;
        end
        S_FILL: begin
          r_mem_write <= 1'b1;
          r_mem_addr  <= r_addr;
          r_mem_wdata <= r_value;
          r_addr      <= w_addr_inc;
          r_count     <= r_count - COUNT_ONE;
          if (r_count == '0) r_state <= DONE_STATE;
        end
        S_DRAW_WAIT: if (gpu_ready && !r_gpu_draw) r_state <= DONE_STATE;
        S_ACK: if (!is_transmitting) begin
          r_transmit <= 1'b1;
          r_tx_byte  <= r_ack_byte;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are masked while rst is high so none coincide with a reset cycle.
  assign transmit  = r_transmit  & ~rst;
  assign mem_read  = r_mem_read  & ~rst;
  assign mem_write = r_mem_write & ~rst;
  assign gpu_draw  = r_gpu_draw  & ~rst;
  assign mem_addr  = rst ? '0 : r_mem_addr;
  assign mem_wdata = rst ? '0 : r_mem_wdata;
  assign tx_byte   = r_tx_byte;
  assign gpu_addr  = r_gpu_addr;
  assign gpu_lines = r_gpu_lines;
  assign gpu_x     = r_gpu_x;
  assign gpu_y     = r_gpu_y;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cmd_controller.sv
// ============================================================================
// tb_cmd_controller : scoreboard bench with frame-level reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cmd_controller;

  logic        clk = 1'b0;
  logic        rst, received, is_transmitting, gpu_ready;
  logic [7:0]  rx_byte, mem_rdata, tx_byte, mem_wdata;
  logic        transmit, mem_read, mem_write, gpu_draw, busy;
  logic [15:0] mem_addr, gpu_addr;
  logic [3:0]  gpu_lines, gpu_x, gpu_y;

  always #5 clk = ~clk;

  cmd_controller #(
    .ADDR_WIDTH(16), .COUNT_WIDTH(8), .TIMEOUT_CYCLES(16), .ACK_ENABLE(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
    .is_transmitting(is_transmitting), .transmit(transmit), .tx_byte(tx_byte),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .gpu_draw(gpu_draw),
    .gpu_addr(gpu_addr), .gpu_lines(gpu_lines), .gpu_x(gpu_x), .gpu_y(gpu_y),
    .gpu_ready(gpu_ready), .busy(busy)
  );

  logic [7:0]  mem_arr [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  tx_q [$];
  logic [23:0] wr_q [$];
  logic [27:0] gpu_q [$];
  logic [7:0]  fb [$];
  int          wr_cyc [$];
  int          total = 0, bad = 0, cyc = 0, wr_seen = 0, last_tx_cyc = 0;
  int          tx_cnt = 0, gpu_cnt = 0;

  assign is_transmitting = (tx_cnt != 0);
  assign gpu_ready       = (gpu_cnt == 0);

  // Environment: 1-cycle-latency memory, UART transmitter and GPU busy timers.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read)  mem_rdata <= mem_arr[mem_addr];
    if (mem_write) mem_arr[mem_addr] <= mem_wdata;
    if (transmit) tx_cnt <= $urandom_range(2, 8);
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    if (gpu_draw) gpu_cnt <= $urandom_range(2, 6);
    else if (gpu_cnt != 0) gpu_cnt <= gpu_cnt - 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) chk("rst_strobes", {28'd0, transmit, mem_read, mem_write, gpu_draw}, 32'd0);
    if (transmit) begin
      last_tx_cyc = cyc;
      chk("tx_while_busy", {31'd0, is_transmitting}, 32'd0);
      chk("tx_gpu_idle", {31'd0, gpu_ready}, 32'd1);
      if (tx_q.size() == 0) chk("tx_unexpected", {24'd0, tx_byte}, 32'hFFFF_FFFF);
      else chk("tx_byte", {24'd0, tx_byte}, {24'd0, tx_q.pop_front()});
    end
    if (mem_write) begin
      wr_seen++;
      wr_cyc.push_back(cyc);
      if (wr_q.size() == 0) chk("wr_unexpected", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      else chk("mem_write", {8'd0, mem_addr, mem_wdata}, {8'd0, wr_q.pop_front()});
    end
    if (gpu_draw) begin
      if (gpu_q.size() == 0) chk("draw_unexpected", {gpu_addr, 16'd0}, 32'hFFFF_FFFF);
      else chk("gpu_draw", {4'd0, gpu_addr, gpu_lines, gpu_x, gpu_y}, {4'd0, gpu_q.pop_front()});
    end
  end

  // Reference model: derives every effect of the frame in fb from the frame rules.
  task automatic model_frame();
    int          n;
    logic [15:0] a;
    logic [3:0]  op;
    op = fb[0][3:0];
    n  = fb[1] + 1;
    a  = {fb[2], fb[3]};
    case (op)
      4'd1: for (int i = 0; i < n; i++) tx_q.push_back(ref_mem[16'(a + i)]);
      4'd2: begin
        for (int i = 0; i < n; i++) begin
          wr_q.push_back({16'(a + i), fb[4 + i]});
          ref_mem[16'(a + i)] = fb[4 + i];
        end
        tx_q.push_back(8'hA5);
      end
      4'd3: begin
        gpu_q.push_back({fb[2], fb[3], fb[0][7:4], fb[1]});
        tx_q.push_back(8'hA5);
      end
      4'd4: begin
        for (int i = 0; i < n; i++) begin
          wr_q.push_back({16'(a + i), fb[4]});
          ref_mem[16'(a + i)] = fb[4];
        end
        tx_q.push_back(8'hA5);
      end
      default: tx_q.push_back(8'hEE);
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    received = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    received = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_frame(input bit junk);
    for (int i = 0; i < fb.size(); i++)
      send_byte(fb[i], (i == fb.size() - 1) ? 0 : int'($urandom_range(0, 3)));
    if (junk) send_byte(8'h09, 0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!(busy == 1'b0 && tx_q.size() == 0 && wr_q.size() == 0 && gpu_q.size() == 0)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, n < 3000}, 32'd1);
  endtask

  task automatic run(input bit junk, input string name);
    model_frame();
    send_frame(junk);
    wait_idle(name);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int          d, seen0, kind;
    logic [3:0]  arg;
    logic [15:0] a;
    logic [7:0]  cnt;
    rst = 1'b1; received = 1'b0; rx_byte = 8'h00; mem_rdata = 8'h00;
    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] = 8'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_gpu", {16'd0, gpu_lines, gpu_x, gpu_y, 4'd0}, 32'd0);
    chk("rst_gpu_addr", {16'd0, gpu_addr}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    mem_arr[16'h0120] = 8'h11; mem_arr[16'h0121] = 8'h22; mem_arr[16'h0122] = 8'h33;
    ref_mem[16'h0120] = 8'h11; ref_mem[16'h0121] = 8'h22; ref_mem[16'h0122] = 8'h33;
    fb = '{8'h01, 8'h02, 8'h01, 8'h20};                   run(1, "read_done");
    fb = '{8'h02, 8'h01, 8'h40, 8'h00, 8'hAA, 8'hBB};     run(0, "write_done");
    fb = '{8'h01, 8'h01, 8'h40, 8'h00};                   run(0, "readback_done");
    wr_cyc.delete();
    fb = '{8'h04, 8'h02, 8'hFF, 8'hFF, 8'h5C};            run(1, "fill_wrap_done");
    chk("fill_nwr", wr_cyc.size(), 32'd3);
    if (wr_cyc.size() == 3) chk("fill_consec", wr_cyc[2] - wr_cyc[0], 32'd2);
    fb = '{8'h53, 8'h12, 8'h03, 8'h00};                   run(1, "draw_done");

    // Inter-byte timeout: header and count, then silence.
    tx_q.push_back(8'hEE);
    send_byte(8'h02, 1);
    send_byte(8'h00, 0);
    d = cyc;
    wait_idle("timeout_done");
    d = last_tx_cyc - d;
    chk("timeout_delay", {31'd0, d >= 15 && d <= 19}, 32'd1);
    chk("timeout_busy", {31'd0, busy}, 32'd0);

    fb = '{8'h09};                                        run(0, "badop_done");

    // Reset in the middle of a 256-byte fill; region pre-set to the fill value.
    for (int i = 16'h1000; i < 16'h1100; i++) begin
      mem_arr[i] = 8'h77;
      ref_mem[i] = 8'h77;
    end
    wr_seen = 0;
    fb = '{8'h04, 8'hFF, 8'h10, 8'h00, 8'h77};
    model_frame();
    send_frame(0);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    seen0 = wr_seen;
    wr_q.delete();
    tx_q.delete();
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("rst_writes_stop", wr_seen, seen0);
    chk("rst_partial", {31'd0, seen0 > 0 && seen0 < 256}, 32'd1);
    chk("rst_busy_after", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 9);
      arg  = 4'($urandom);
      a    = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                         : 16'($urandom);
      cnt  = 8'($urandom_range(0, 7));
      fb.delete();
      if (kind < 2) begin
        fb = '{{arg, 4'd1}, cnt, a[15:8], a[7:0]};
        run(1, "rand_read");
      end else if (kind < 4) begin
        fb = '{{arg, 4'd2}, cnt, a[15:8], a[7:0]};
        for (int i = 0; i <= cnt; i++) fb.push_back(8'($urandom));
        run(0, "rand_write");
      end else if (kind < 6) begin
        if ($urandom_range(0, 3) == 0) cnt = 8'($urandom_range(8, 63));
        fb = '{{arg, 4'd4}, cnt, a[15:8], a[7:0], 8'($urandom)};
        run(1, "rand_fill");
      end else if (kind < 8) begin
        fb = '{{arg, 4'd3}, 8'($urandom), a[15:8], a[7:0]};
        run(1, "rand_draw");
      end else begin
        d  = $urandom_range(0, 11);
        fb = '{{arg, (d == 0) ? 4'd0 : 4'(d + 4)}};
        run(0, "rand_badop");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
